mips32_mem_dump: RTL and testbench

Read-back engine for the MIPS32 core's word memory `Mem`: on a start command it reads a contiguous block of words through a synchronous read port and streams them out over a valid/ready interface, each beat tagged with its word address. It is the reading counterpart to the bench/loader path that writes the program and data image into `Mem`. It lets result regions such as `Mem[120..121]` be dumped by hardware instead of by hierarchical `$display`.

---
 rtl/mips32_dbg_pkg.sv | 25 ++
 rtl/mips32_skid_fifo.sv | 43 ++++
 rtl/mips32_mem_dump.sv | 177 +++++++++++++++++
 tb/tb_mips32_mem_dump.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips32_dbg_pkg.sv
// Shared types for the MIPS32 memory read-back engine.
// With MIPS32_MEM_DUMP_CSUM_EN defined the state set gains ST_CSUM, the
// state that emits the trailing checksum beat.
package mips32_dbg_pkg;

    localparam int DBG_ADDR_W = 10;
    localparam int DBG_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
`ifdef MIPS32_MEM_DUMP_CSUM_EN
        ST_CSUM = 2'd2,
`endif
        ST_FIN  = 2'd3
    } dump_state_t;

    // One output beat: word, its word address, and the end-of-transfer flag.
    typedef struct packed {
        logic [DBG_DATA_W-1:0] data;
        logic [DBG_ADDR_W-1:0] addr;
        logic                  last;
    } beat_t;

endpackage

// File: rtl/mips32_skid_fifo.sv
// Two-entry synchronous FIFO of output beats. Push and pop may happen in the
// same cycle; the caller never pushes when full or pops when empty.
module mips32_skid_fifo
    import mips32_dbg_pkg::*;
#(
    parameter type T = beat_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  T           push_data,
    input  logic       pop,
    output T           head,
    output logic [1:0] count
);

    T     entries [0:1];
    logic wr_ptr;
    logic rd_ptr;

    // Storage, pointers and occupancy; reset empties and clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries[0] <= '0;
            entries[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/mips32_mem_dump.sv
// Read-back engine for the MIPS32 word memory: reads a block of words through
// a one-cycle-latency read port and streams them out tagged with addresses.
// Output handshake: a beat transfers in any cycle where out_valid and
// out_ready are both 1; once out_valid is raised, out_data/out_addr/out_last
// hold until that transfer.
// Optional: MIPS32_MEM_DUMP_CSUM_EN appends a checksum beat to each transfer.
module mips32_mem_dump
    import mips32_dbg_pkg::*;
#(
    parameter int ADDR_W = DBG_ADDR_W,
    parameter int DATA_W = DBG_DATA_W
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } beat_w_t;

    dump_state_t       state, state_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   remaining;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic              inflight_last;
    logic              issue;
    logic              pop;
    logic [2:0]        occ;
    logic [1:0]        fifo_count;
    beat_w_t           head;
    beat_w_t           push_beat;
    logic              accept;

`ifdef MIPS32_MEM_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum;
    logic [ADDR_W-1:0] end_addr;
`endif

    assign accept    = (state == ST_IDLE) && start;
    assign push_beat = '{data: mem_rdata, addr: inflight_addr, last: inflight_last};
    assign busy      = (state != ST_IDLE);
    assign mem_rd_en = issue;
    assign mem_addr  = rd_ptr;

    mips32_skid_fifo #(.T(beat_w_t)) u_fifo (
        .clk       (clk1),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (push_beat),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state, output beat mux and read-issue decision.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_addr  = '0;
        out_last  = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (count == '0) begin
`ifdef MIPS32_MEM_DUMP_CSUM_EN
                        state_nxt = ST_CSUM;
`else
                        state_nxt = ST_FIN;
`endif
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                out_valid = (fifo_count != 2'd0);
                if (out_valid) begin
                    out_data = head.data;
                    out_addr = head.addr;
`ifdef MIPS32_MEM_DUMP_CSUM_EN
                    out_last = 1'b0;
`else
                    out_last = head.last;
`endif
                end
                pop = out_valid && out_ready;
                if (pop && head.last) begin
`ifdef MIPS32_MEM_DUMP_CSUM_EN
                    state_nxt = ST_CSUM;
`else
                    state_nxt = ST_FIN;
`endif
                end
            end
`ifdef MIPS32_MEM_DUMP_CSUM_EN
            ST_CSUM: begin
                out_valid = 1'b1;
                out_data  = csum;
                out_addr  = end_addr;
                out_last  = 1'b1;
                if (out_ready) state_nxt = ST_FIN;
            end
`endif
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Words buffered plus in flight after this cycle must stay within two.
        occ   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        issue = (state == ST_RUN) && (remaining != '0) && (occ < 3'd2);
    end

    // Read pointer, issue countdown and the one-deep in-flight tag register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            inflight_last <= 1'b0;
        end else begin
            if (accept) begin
                rd_ptr    <= base_addr;
                remaining <= count;
            end else if (issue) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            inflight      <= issue;
            inflight_addr <= rd_ptr;
            inflight_last <= (remaining == {{ADDR_W{1'b0}}, 1'b1});
        end
    end

`ifdef MIPS32_MEM_DUMP_CSUM_EN
    // Running checksum of accepted data words and the checksum beat address.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            csum     <= '0;
            end_addr <= '0;
        end else if (accept) begin
            csum     <= '0;
            end_addr <= base_addr + count[ADDR_W-1:0];
        end else if ((state == ST_RUN) && pop) begin
            csum <= csum + head.data;
        end
    end
`endif

endmodule

// File: tb/tb_mips32_mem_dump.sv
// Self-checking bench for mips32_mem_dump: table of transfers, hand-written
// reset and busy-start sequences, and randomized transfers checked against a
// queue-based model of the expected beat stream.
module tb_mips32_mem_dump;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW + AW + 1;
`ifdef MIPS32_MEM_DUMP_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy, done, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;

    logic [DW-1:0] mem [0:1023];
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   cnt;
        int            rmode;
        bit            poke;
        int            exp_done;
        string         name;
    } vec_t;

    vec_t vecs [8];

    // Clock and synchronous-read memory model.
    always #5 clk1 = ~clk1;
    always @(posedge clk1) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    mips32_mem_dump dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // One full transfer: stimulus, model, and end-of-transfer checks.
    task automatic run_xfer(input logic [AW-1:0] b, input logic [AW:0] n, input int rmode,
                            input bit poke, input int exp_done, input string tag);
        logic [BW-1:0] exp_q[$];
        logic [BW-1:0] held, got;
        logic [DW-1:0] sum;
        logic          hold;
        int cyc, done_cyc, first_beat, reads, data_pops, hs, max_occ, busy_err, stab_err, extra;
        exp_q.delete();
        sum = '0;
        for (int i = 0; i < int'(n); i++) begin
            logic [AW-1:0] a;
            a = AW'((int'(b) + i) % 1024);
            exp_q.push_back({mem[a], a, (CS == 0) && (i == int'(n) - 1)});
            sum = sum + mem[a];
        end
        if (CS == 1) exp_q.push_back({sum, AW'((int'(b) + int'(n)) % 1024), 1'b1});
        cyc = 0; done_cyc = -1; first_beat = -1; reads = 0; data_pops = 0; hs = 0;
        max_occ = 0; busy_err = 0; stab_err = 0; extra = 0; hold = 1'b0; held = '0;
        @(posedge clk1); #1;
        start = 1'b1; base_addr = b; count = n; out_ready = rdy(rmode, 0);
        while (done_cyc < 0 && cyc < 4 * int'(n) + 50) begin
            @(negedge clk1);
            if (busy !== (cyc >= 1)) busy_err++;
            got = {out_data, out_addr, out_last};
            if (hold && (!out_valid || got !== held)) stab_err++;
            if (mem_rd_en) reads++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) extra++;
                else check({tag, " beat"}, 64'(got), 64'(exp_q.pop_front()));
                if (first_beat < 0) first_beat = cyc;
                if (hs < int'(n)) data_pops++;
                hs++;
            end
            if (reads - data_pops > max_occ) max_occ = reads - data_pops;
            hold = out_valid && !out_ready;
            held = got;
            if (done) done_cyc = cyc;
            @(posedge clk1); #1;
            cyc++;
            start     = poke && (cyc == 2);
            base_addr = AW'($urandom);
            count     = (AW + 1)'($urandom_range(1, 2047));
            out_ready = rdy(rmode, cyc);
        end
        @(negedge clk1);
        check({tag, " post_done_idle"}, {62'd0, done, busy}, 64'd0);
        check({tag, " done_seen"}, 64'(done_cyc >= 0), 64'd1);
        if (exp_done >= 0) begin
            check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
            if (int'(n) > 0 || CS == 1)
                check({tag, " first_beat_cycle"}, 64'(first_beat), 64'((int'(n) > 0) ? 3 : 1));
        end
        check({tag, " missing_beats"}, 64'(exp_q.size()), 64'd0);
        check({tag, " extra_beats"}, 64'(extra), 64'd0);
        check({tag, " read_count"}, 64'(reads), 64'(n));
        check({tag, " occupancy_le2"}, 64'(max_occ <= 2), 64'd1);
        check({tag, " busy_window"}, 64'(busy_err), 64'd0);
        check({tag, " output_hold"}, 64'(stab_err), 64'd0);
    endtask

    // Abort a 16-word transfer after 5 beats with reset and check outputs.
    task automatic reset_mid_op();
        int k, cyc;
        k = 0; cyc = 0;
        @(posedge clk1); #1;
        start = 1'b1; base_addr = 10'd200; count = 11'd16; out_ready = 1'b1;
        while (k < 5 && cyc < 40) begin
            @(negedge clk1);
            if (out_valid && out_ready) begin
                check("rst_seq beat", 64'({out_data, out_addr}),
                      64'({mem[10'd200 + AW'(k)], 10'd200 + AW'(k)}));
                k++;
            end
            @(posedge clk1); #1;
            start = 1'b0;
            cyc++;
        end
        check("rst_seq beats_before_reset", 64'(k), 64'd5);
        @(posedge clk1); #1;
        rst_n = 1'b0;
        #1;
        check("rst_seq outputs_reset",
              64'({busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last}), 64'd0);
        repeat (2) @(posedge clk1);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[120] = 32'd55;
        mem[121] = 32'd100;

        vecs[0] = '{10'd120,  11'd2,    0, 1'b0, 5 + CS,    "plan_120"};
        vecs[1] = '{10'd1022, 11'd4,    0, 1'b0, 7 + CS,    "wrap"};
        vecs[2] = '{10'd0,    11'd0,    0, 1'b0, 1 + CS,    "zero_count"};
        vecs[3] = '{10'd300,  11'd8,    1, 1'b0, -1,        "backpressure"};
        vecs[4] = '{10'd500,  11'd6,    0, 1'b1, 9 + CS,    "start_while_busy"};
        vecs[5] = '{10'd1023, 11'd1,    0, 1'b0, 4 + CS,    "single_wrap"};
        vecs[6] = '{10'd5,    11'd1024, 0, 1'b0, 1027 + CS, "full_memory"};
        vecs[7] = '{10'd10,   11'd3,    2, 1'b0, -1,        "random_ready"};

        repeat (2) @(posedge clk1);
        @(negedge clk1);
        check("reset_outputs",
              64'({busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last}), 64'd0);
        @(posedge clk1); #1 rst_n = 1'b1;

        for (int v = 0; v < 8; v++)
            run_xfer(vecs[v].base, vecs[v].cnt, vecs[v].rmode, vecs[v].poke, vecs[v].exp_done, vecs[v].name);

        reset_mid_op();
        run_xfer(10'd0, 11'd1, 0, 1'b0, 4 + CS, "after_reset");

        for (int r = 0; r < 20; r++) begin
            logic [AW-1:0] b;
            logic [AW:0]   n;
            int            m;
            b = AW'($urandom_range(0, 1023));
            n = (AW + 1)'($urandom_range(0, 40));
            m = $urandom_range(0, 2);
            run_xfer(b, n, m, (n != 0) && ($urandom_range(0, 1) == 1),
                     (m == 0) ? ((n == 0) ? 1 : int'(n) + 3) + CS : -1, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
